// File: rtl/cpu_pkg.sv
// Shared types, encodings and helpers for the multicycle ARM-subset core.
package cpu_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 16;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  // Data-processing commands (bits 24:21)
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  // Condition codes (bits 31:28)
  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  // Instruction classes (bits 27:26)
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_UND = 2'b11;

  // Bit positions inside the NZCV nibble
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  // Evaluate a condition field against the current NZCV flags; NV acts as AL.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v;
    n = flags[FLAG_N];
    z = flags[FLAG_Z];
    c = flags[FLAG_C];
    v = flags[FLAG_V];
    case (cond)
      COND_EQ: cond_pass = z;
      COND_NE: cond_pass = !z;
      COND_CS: cond_pass = c;
      COND_CC: cond_pass = !c;
      COND_MI: cond_pass = n;
      COND_PL: cond_pass = !n;
      COND_VS: cond_pass = v;
      COND_VC: cond_pass = !v;
      COND_HI: cond_pass = c && !z;
      COND_LS: cond_pass = !c || z;
      COND_GE: cond_pass = (n == v);
      COND_LT: cond_pass = (n != v);
      COND_GT: cond_pass = !z && (n == v);
      COND_LE: cond_pass = z || (n != v);
      COND_AL, COND_NV: cond_pass = 1'b1;
      default: cond_pass = 1'b1;
    endcase
  endfunction

  // True for the data-processing commands this core implements.
  function automatic logic cmd_legal(input logic [3:0] cmd);
    case (cmd)
      CMD_AND, CMD_SUB, CMD_ADD, CMD_CMP, CMD_ORR, CMD_MOV: cmd_legal = 1'b1;
      default: cmd_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: data-processing result plus the NZCV it would produce.
module cpu_alu
  import cpu_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      cmd,
  input  logic [3:0]      flags_in,
  output logic [XLEN-1:0] result,
  output logic [3:0]      flags_out
);

  logic [XLEN:0] sum;
  logic [XLEN:0] diff;
  logic          valid;

  // Compute result; C/V are only touched by arithmetic, N/Z by every legal op.
  always_comb begin
    sum       = {1'b0, a} + {1'b0, b};
    diff      = {1'b0, a} + {1'b0, ~b} + {{XLEN{1'b0}}, 1'b1};
    result    = '0;
    flags_out = flags_in;
    valid     = 1'b1;
    case (cmd)
      CMD_ADD: begin
        result            = sum[XLEN-1:0];
        flags_out[FLAG_C] = sum[XLEN];
        flags_out[FLAG_V] = (a[XLEN-1] == b[XLEN-1]) && (result[XLEN-1] != a[XLEN-1]);
      end
      CMD_SUB, CMD_CMP: begin
        result            = diff[XLEN-1:0];
        flags_out[FLAG_C] = diff[XLEN];
        flags_out[FLAG_V] = (a[XLEN-1] != b[XLEN-1]) && (result[XLEN-1] != a[XLEN-1]);
      end
      CMD_AND: result = a & b;
      CMD_ORR: result = a | b;
      CMD_MOV: result = b;
      default: valid = 1'b0;
    endcase
    if (valid) begin
      flags_out[FLAG_N] = result[XLEN-1];
      flags_out[FLAG_Z] = (result == '0);
    end
  end

endmodule

// File: rtl/cpu_multicycle.sv
// Multicycle ARM-subset core: FETCH -> DECODE -> EXEC -> [MEM] -> WB.
module cpu_multicycle
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ready,
  input  logic [31:0]       dmem_rdata,
  output logic [31:0]       dbg_pc,
  output logic [31:0]       dbg_instr,
  output logic [31:0]       dbg_result,
  output logic [3:0]        dbg_flags,
  output logic              retire,
  output logic              illegal
);

  state_t          state;
  state_t          state_nxt;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] regs [NREGS];
  logic [XLEN-1:0] opa;
  logic [XLEN-1:0] opm;
  logic [XLEN-1:0] opd;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] result;
  logic [3:0]      flags;
  logic            skip;

  // Instruction fields
  logic [3:0]  cond, cmd, rn, rd, rm, rot;
  logic [1:0]  op;
  logic        imm_sel, s_bit, l_bit, u_bit;
  logic [7:0]  imm8;
  logic [11:0] imm12;
  logic [23:0] imm24;

  assign cond    = instr[31:28];
  assign op      = instr[27:26];
  assign imm_sel = instr[25];
  assign cmd     = instr[24:21];
  assign u_bit   = instr[23];
  assign s_bit   = instr[20];
  assign l_bit   = instr[20];
  assign rn      = instr[19:16];
  assign rd      = instr[15:12];
  assign rot     = instr[11:8];
  assign imm8    = instr[7:0];
  assign imm12   = instr[11:0];
  assign imm24   = instr[23:0];
  assign rm      = instr[3:0];

  logic [XLEN-1:0]   pc_plus4, pc_plus8;
  logic [XLEN-1:0]   rn_val, rm_val, rd_val;
  logic [2*XLEN-1:0] imm_dbl;
  logic [XLEN-1:0]   imm_rot, op2, alu_res, mem_addr, br_target;
  logic [3:0]        alu_flags;
  logic              cond_ok, dp_legal, is_illegal, is_load, is_branch, wr_en;
  logic              fetch_accept, mem_done;

  assign pc_plus4 = pc + XLEN'(4);
  assign pc_plus8 = pc + XLEN'(8);

  // R15 reads see the pipeline-visible PC+8
  assign rn_val = (rn == 4'd15) ? pc_plus8 : regs[rn];
  assign rm_val = (rm == 4'd15) ? pc_plus8 : regs[rm];
  assign rd_val = (rd == 4'd15) ? pc_plus8 : regs[rd];

  // Rotate-right of imm8 by 2*rot, done as a shift of the doubled word
  assign imm_dbl   = {24'b0, imm8, 24'b0, imm8};
  assign imm_rot   = XLEN'(imm_dbl >> {rot, 1'b0});
  assign op2       = imm_sel ? imm_rot : opm;
  assign mem_addr  = u_bit ? (opa + XLEN'(imm12)) : (opa - XLEN'(imm12));
  assign br_target = pc_plus8 + {{6{imm24[23]}}, imm24, 2'b00};

  assign cond_ok    = cond_pass(cond, flags);
  assign dp_legal   = (op == OP_DP) && cmd_legal(cmd);
  assign is_illegal = ((op == OP_DP) && !cmd_legal(cmd)) || (op == OP_UND);
  assign is_load    = (op == OP_MEM) && l_bit;
  assign is_branch  = (op == OP_BR);
  assign wr_en      = !skip && (rd != 4'd15) && ((dp_legal && (cmd != CMD_CMP)) || is_load);

  cpu_alu u_alu (
    .a         (opa),
    .b         (op2),
    .cmd       (cmd),
    .flags_in  (flags),
    .result    (alu_res),
    .flags_out (alu_flags)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= state_nxt;
  end

  // Next-state logic and handshake-completion strobes
  always_comb begin
    state_nxt    = state;
    fetch_accept = 1'b0;
    mem_done     = 1'b0;
    case (state)
      FETCH: begin
        if (imem_req && imem_ready) begin
          fetch_accept = 1'b1;
          state_nxt    = DECODE;
        end
      end
      DECODE: state_nxt = cond_ok ? EXEC : WB;
      EXEC:   state_nxt = (op == OP_MEM) ? MEM : WB;
      MEM: begin
        if (dmem_ready) begin
          mem_done  = 1'b1;
          state_nxt = WB;
        end
      end
      WB:      state_nxt = FETCH;
      default: state_nxt = FETCH;
    endcase
  end

  // Architectural state, operand latches and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc         <= RESET_PC;
      instr      <= '0;
      opa        <= '0;
      opm        <= '0;
      opd        <= '0;
      target     <= '0;
      result     <= '0;
      flags      <= '0;
      skip       <= 1'b0;
      imem_req   <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      retire     <= 1'b0;
      illegal    <= 1'b0;
      for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
    end else begin
      imem_req <= (state_nxt == FETCH);
      dmem_req <= (state_nxt == MEM);
      retire   <= (state_nxt == WB);
      illegal  <= (state_nxt == WB) && (state == EXEC) && is_illegal;

      if (fetch_accept) instr <= imem_rdata;

      if (state == DECODE) begin
        opa  <= rn_val;
        opm  <= rm_val;
        opd  <= rd_val;
        skip <= !cond_ok;
      end

      if (state == EXEC) begin
        if (dp_legal) begin
          result <= alu_res;
          if (s_bit || (cmd == CMD_CMP)) flags <= alu_flags;
        end
        if (op == OP_MEM) begin
          dmem_addr  <= ADDR_W'(mem_addr);
          dmem_we    <= !l_bit;
          dmem_wdata <= opd;
        end
        if (is_branch) target <= br_target;
      end

      if (mem_done && is_load) result <= dmem_rdata;

      if (state == WB) begin
        if (wr_en) regs[rd] <= result;
        pc <= (is_branch && !skip) ? target : pc_plus4;
      end
    end
  end

  assign imem_addr  = ADDR_W'(pc);
  assign dbg_pc     = pc;
  assign dbg_instr  = instr;
  assign dbg_result = result;
  assign dbg_flags  = flags;

endmodule

// File: tb/tb_cpu_multicycle.sv
// Directed bench for cpu_multicycle with wait-state instruction/data memories.
module tb_cpu_multicycle;

  localparam int unsigned ADDR_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ready;
  logic [31:0]       imem_rdata;
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [31:0]       dmem_wdata;
  logic              dmem_ready;
  logic [31:0]       dmem_rdata;
  logic [31:0]       dbg_pc;
  logic [31:0]       dbg_instr;
  logic [31:0]       dbg_result;
  logic [3:0]        dbg_flags;
  logic              retire;
  logic              illegal;

  cpu_multicycle #(.RESET_PC(32'h0000_0000), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ready (dmem_ready),
    .dmem_rdata (dmem_rdata),
    .dbg_pc     (dbg_pc),
    .dbg_instr  (dbg_instr),
    .dbg_result (dbg_result),
    .dbg_flags  (dbg_flags),
    .retire     (retire),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  // Memory models: ready rises after a programmable number of wait cycles
  logic [31:0] imem [0:63];
  logic [31:0] dmem [0:15];
  int imem_wait = 0;
  int dmem_wait = 0;
  int icnt = 0;
  int dcnt = 0;

  assign imem_ready = imem_req && (icnt >= imem_wait);
  assign imem_rdata = imem[imem_addr[7:2]];
  assign dmem_ready = dmem_req && (dcnt >= dmem_wait);
  assign dmem_rdata = dmem[dmem_addr[5:2]];

  always @(posedge clk) begin
    if (!imem_req || imem_ready) icnt <= 0;
    else                         icnt <= icnt + 1;
    if (!dmem_req || dmem_ready) dcnt <= 0;
    else                         dcnt <= dcnt + 1;
    if (reset) begin
      for (int i = 0; i < 16; i++) dmem[i] <= 32'h0;
    end else if (dmem_req && dmem_ready && dmem_we) begin
      dmem[dmem_addr[5:2]] <= dmem_wdata;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Per-instruction observations gathered while waiting for retire
  int          lat;
  int          ireq_n;
  int          dreq_n;
  logic [31:0] ia0;
  logic        ia_stable;
  logic [31:0] da0;
  logic [31:0] dw0;
  logic        dwe0;

  task automatic wait_retire(input string tag);
    logic found;
    found     = 1'b0;
    lat       = 0;
    ireq_n    = 0;
    dreq_n    = 0;
    ia_stable = 1'b1;
    for (int i = 0; i < 64 && !found; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (imem_req) begin
        if (ireq_n == 0) ia0 = imem_addr;
        else if (imem_addr !== ia0) ia_stable = 1'b0;
        ireq_n++;
      end
      if (dmem_req) begin
        if (dreq_n == 0) begin
          da0  = dmem_addr;
          dw0  = dmem_wdata;
          dwe0 = dmem_we;
        end
        dreq_n++;
      end
      if (retire) found = 1'b1;
    end
    if (!found) check({tag, "_retire"}, 32'(retire), 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 64; i++) imem[i] = 32'hEAFF_FFFE;
    imem[0]  = 32'hE3A0_1005; // MOV  R1,#5
    imem[1]  = 32'hE3A0_2003; // MOV  R2,#3
    imem[2]  = 32'hE081_3002; // ADD  R3,R1,R2
    imem[3]  = 32'hE052_4001; // SUBS R4,R2,R1
    imem[4]  = 32'hE3A0_04FF; // MOV  R0,#0xFF ror 8
    imem[5]  = 32'hE351_0005; // CMP  R1,#5
    imem[6]  = 32'h1081_5001; // ADDNE R5,R1,R1
    imem[7]  = 32'hE285_7001; // ADD  R7,R5,#1
    imem[8]  = 32'hE580_1004; // STR  R1,[R0,#4]
    imem[9]  = 32'hE590_6004; // LDR  R6,[R0,#4]
    imem[10] = 32'hE28F_8000; // ADD  R8,R15,#0
    imem[11] = 32'hE580_3008; // STR  R3,[R0,#8]

    repeat (3) @(posedge clk);
    #1;
    check("rst_imem_req",  32'(imem_req),  32'd0);
    check("rst_imem_addr", imem_addr,      32'h0);
    check("rst_dmem_req",  32'(dmem_req),  32'd0);
    check("rst_retire",    32'(retire),    32'd0);
    check("rst_flags",     32'(dbg_flags), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    wait_retire("mov_r1");
    check("mov_r1_result", dbg_result, 32'd5);
    wait_retire("mov_r2");
    check("mov_r2_lat",    32'(lat),   32'd4);
    check("mov_r2_result", dbg_result, 32'd3);
    wait_retire("add");
    check("add_lat",    32'(lat),       32'd4);
    check("add_result", dbg_result,     32'd8);
    check("add_flags",  32'(dbg_flags), 32'h0);
    wait_retire("subs");
    check("subs_lat",    32'(lat),       32'd4);
    check("subs_result", dbg_result,     32'hFFFF_FFFE);
    check("subs_flags",  32'(dbg_flags), 32'h8);
    wait_retire("mov_rot");
    check("mov_rot_result", dbg_result,     32'hFF00_0000);
    check("mov_rot_flags",  32'(dbg_flags), 32'h8);
    wait_retire("cmp");
    check("cmp_result", dbg_result,     32'h0);
    check("cmp_flags",  32'(dbg_flags), 32'h6);
    wait_retire("addne");
    check("addne_lat",    32'(lat),   32'd3);
    check("addne_pc",     dbg_pc,     32'h18);
    check("addne_result", dbg_result, 32'h0);
    wait_retire("add_r7");
    check("add_r7_result", dbg_result, 32'd1);

    dmem_wait = 2;
    wait_retire("str");
    check("str_lat",   32'(lat),    32'd7);
    check("str_req_n", 32'(dreq_n), 32'd3);
    check("str_addr",  da0,         32'hFF00_0004);
    check("str_wdata", dw0,         32'd5);
    check("str_we",    32'(dwe0),   32'd1);
    wait_retire("ldr");
    check("ldr_lat",    32'(lat),    32'd7);
    check("ldr_req_n",  32'(dreq_n), 32'd3);
    check("ldr_we",     32'(dwe0),   32'd0);
    check("ldr_result", dbg_result,  32'd5);

    dmem_wait = 1000;
    wait_retire("add_pc");
    check("add_pc_result", dbg_result, 32'h30);

    // Reset while the STR R3 sits in MEM
    for (int i = 0; i < 20 && !dmem_req; i++) begin
      @(posedge clk);
      #1;
    end
    check("mem_pending", 32'(dmem_req), 32'd1);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("rmem_dmem_req",  32'(dmem_req),  32'd0);
    check("rmem_imem_req",  32'(imem_req),  32'd0);
    check("rmem_imem_addr", imem_addr,      32'h0);
    check("rmem_flags",     32'(dbg_flags), 32'd0);
    check("rmem_result",    dbg_result,     32'd0);
    check("rmem_instr",     dbg_instr,      32'd0);

    imem[0] = 32'hE281_8007; // ADD  R8,R1,#7
    imem[1] = 32'hE086_9007; // ADD  R9,R6,R7
    imem[2] = 32'hE28F_A000; // ADD  R10,R15,#0
    imem[3] = 32'hE359_0001; // CMP  R9,#1
    imem[4] = 32'hEAFF_FFFE; // B    .
    dmem_wait = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    wait_retire("p2_add_r8");
    check("p2_fetch_addr", ia0,        32'h0);
    check("p2_r8_result",  dbg_result, 32'd7);
    wait_retire("p2_add_r9");
    check("p2_r9_result", dbg_result, 32'd0);
    wait_retire("p2_add_pc");
    check("p2_pc_result", dbg_result, 32'h10);
    wait_retire("p2_cmp");
    check("p2_cmp_flags", 32'(dbg_flags), 32'h8);

    imem_wait = 3;
    wait_retire("b1");
    check("b1_lat",       32'(lat),       32'd7);
    check("b1_ireq_n",    32'(ireq_n),    32'd4);
    check("b1_addr",      ia0,            32'h10);
    check("b1_addr_hold", 32'(ia_stable), 32'd1);
    check("b1_pc",        dbg_pc,         32'h10);
    wait_retire("b2");
    check("b2_lat",       32'(lat),       32'd7);
    check("b2_addr",      ia0,            32'h10);
    check("b2_addr_hold", 32'(ia_stable), 32'd1);

    // Reset while a fetch is stalled
    for (int i = 0; i < 4 && !imem_req; i++) begin
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    check("fetch_pending", 32'(imem_req), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("rfetch_imem_req",  32'(imem_req),  32'd0);
    check("rfetch_imem_addr", imem_addr,      32'h0);
    check("rfetch_flags",     32'(dbg_flags), 32'd0);
    check("rfetch_pc",        dbg_pc,         32'h0);
    imem_wait = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    wait_retire("p3_add_r8");
    check("p3_fetch_addr", ia0,        32'h0);
    check("p3_pc",         dbg_pc,     32'h0);
    check("p3_r8_result",  dbg_result, 32'd7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
